// File: rtl/speed_calc_divider_module_pkg.sv
// rtl/speed_calc_divider_module_pkg.sv - shared constants, FSM encoding and helpers for the speed divider
package speed_calc_divider_module_pkg;

  localparam int SPEED_W = 26;
  localparam logic [SPEED_W-1:0] PULSE_BASE = 26'd390625;

  localparam logic [7:0] WIN_1   = 8'd1;
  localparam logic [7:0] WIN_4   = 8'd4;
  localparam logic [7:0] WIN_16  = 8'd16;
  localparam logic [7:0] WIN_64  = 8'd64;
  localparam logic [7:0] WIN_128 = 8'd128;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_DIV  = 3'd1,
    ST_MODE = 3'd2,
    ST_FILT = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  // Lower switching limit; clamps at zero so the bottom band never wraps.
  function automatic logic [SPEED_W:0] sat_sub(input logic [SPEED_W:0] a, input logic [SPEED_W:0] b);
    return (a >= b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/speed_calc_divider_module_if.sv
// rtl/speed_calc_divider_module_if.sv - timing-stage result in, speed/window results out
interface speed_calc_divider_module_if;
  import speed_calc_divider_module_pkg::*;

  logic [SPEED_W-1:0] speed_pluse_time_cnt_in;
  logic [SPEED_W-1:0] speed_pluse_count_dividend_in;
  logic               speed_cnt_valid_in;
  logic [SPEED_W-1:0] speed_value_out;
  logic               speed_valid_out;
  logic [7:0]         speed_area_count_value_out;
  logic               speed_area_count_valid_out;
  logic               busy_out;
  logic               overrun_out;

  modport master (
    output speed_pluse_time_cnt_in, speed_pluse_count_dividend_in, speed_cnt_valid_in,
    input  speed_value_out, speed_valid_out, speed_area_count_value_out,
           speed_area_count_valid_out, busy_out, overrun_out
  );

  modport slave (
    input  speed_pluse_time_cnt_in, speed_pluse_count_dividend_in, speed_cnt_valid_in,
    output speed_value_out, speed_valid_out, speed_area_count_value_out,
           speed_area_count_valid_out, busy_out, overrun_out
  );

endinterface

// File: rtl/speed_calc_divider_module_div.sv
// rtl/speed_calc_divider_module_div.sv - 26-cycle restoring divider with start/done handshake
module speed_restoring_divider_26
  import speed_calc_divider_module_pkg::*;
(
  input  logic               sys_clk,
  input  logic               reset_n,
  input  logic               start_i,
  input  logic [SPEED_W-1:0] dividend_i,
  input  logic [SPEED_W-1:0] divisor_i,
  output logic [SPEED_W-1:0] quotient_o,
  output logic               done_o,
  output logic               busy_o
);

  logic               busy_q, busy_d;
  logic [4:0]         cnt_q, cnt_d;
  logic [SPEED_W-1:0] dvd_q, dvd_d;
  logic [SPEED_W-1:0] dsr_q, dsr_d;
  logic [SPEED_W:0]   rem_q, rem_d;
  logic [SPEED_W-1:0] quot_q, quot_d;

  logic [SPEED_W:0]   rem_sh;
  logic               rem_ge;

  // Shift in the next dividend bit, then try to subtract the divisor.
  assign rem_sh = {rem_q[SPEED_W-1:0], dvd_q[SPEED_W-1]};
  assign rem_ge = (rem_sh >= {1'b0, dsr_q});

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    dvd_d  = dvd_q;
    dsr_d  = dsr_q;
    rem_d  = rem_q;
    quot_d = quot_q;
    if (start_i && !busy_q) begin
      busy_d = 1'b1;
      cnt_d  = 5'd25;
      dvd_d  = dividend_i;
      dsr_d  = divisor_i;
      rem_d  = '0;
      quot_d = '0;
    end else if (busy_q) begin
      rem_d  = rem_ge ? (rem_sh - {1'b0, dsr_q}) : rem_sh;
      quot_d = {quot_q[SPEED_W-2:0], rem_ge};
      dvd_d  = {dvd_q[SPEED_W-2:0], 1'b0};
      if (cnt_q == 5'd0) begin
        busy_d = 1'b0;
      end else begin
        cnt_d = cnt_q - 5'd1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      dvd_q  <= '0;
      dsr_q  <= '0;
      rem_q  <= '0;
      quot_q <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      dvd_q  <= dvd_d;
      dsr_q  <= dsr_d;
      rem_q  <= rem_d;
      quot_q <= quot_d;
    end
  end

  assign quotient_o = quot_q;
  assign done_o     = busy_q && (cnt_q == 5'd0);
  assign busy_o     = busy_q;

endmodule

// File: rtl/speed_calc_divider_module.sv
// rtl/speed_calc_divider_module.sv - speed = dividend/time, hysteretic window select; SPEED_IIR_FILTER_EN adds an IIR on the speed output
module speed_calc_divider_module
  import speed_calc_divider_module_pkg::*;
#(
  parameter int TH_1_4     = 16,
  parameter int TH_4_16    = 64,
  parameter int TH_16_64   = 256,
  parameter int TH_64_128  = 1024,
  parameter int HYST       = 4,
  parameter int FILT_SHIFT = 3
) (
  input  logic                        sys_clk,
  input  logic                        reset_n,
  speed_calc_divider_module_if.slave  bus
);

  state_e             state_q, state_d;
  logic               div_start, div_done, div_busy;
  logic [SPEED_W-1:0] div_quot;
  logic               zero_q;
  logic [SPEED_W-1:0] quot_sel;
  logic [7:0]         win_nxt_q, win_d;
  logic [7:0]         area_q;
  logic [SPEED_W-1:0] speed_q;
  logic               valid_q;
  logic               overrun_q;
  logic               busy;

  speed_restoring_divider_26 u_div (
    .sys_clk    (sys_clk),
    .reset_n    (reset_n),
    .start_i    (div_start),
    .dividend_i (bus.speed_pluse_count_dividend_in),
    .divisor_i  (bus.speed_pluse_time_cnt_in),
    .quotient_o (div_quot),
    .done_o     (div_done),
    .busy_o     (div_busy)
  );

  assign quot_sel = zero_q ? '0 : div_quot;

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.speed_cnt_valid_in)
                 state_d = (bus.speed_pluse_time_cnt_in != '0) ? ST_DIV : ST_MODE;
      ST_DIV:  if (div_done) state_d = ST_MODE;
`ifdef SPEED_IIR_FILTER_EN
      ST_MODE: state_d = ST_FILT;
      ST_FILT: state_d = ST_DONE;
`else
      ST_MODE: state_d = ST_DONE;
`endif
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    div_start = 1'b0;
    busy      = 1'b1;
    if (state_q == ST_IDLE) begin
      busy      = 1'b0;
      div_start = bus.speed_cnt_valid_in && (bus.speed_pluse_time_cnt_in != '0);
    end
  end

  // Window neighbours and switching bounds for the current window.
  logic [SPEED_W:0] up_bound, lo_bound, up_lim, lo_lim;
  logic [7:0]       up_win, dn_win;
  logic             has_up, has_dn;

  always_comb begin
    up_bound = '0;
    lo_bound = '0;
    up_win   = area_q;
    dn_win   = area_q;
    has_up   = 1'b0;
    has_dn   = 1'b0;
    case (area_q)
      WIN_1: begin
        has_up = 1'b1; up_bound = 27'(TH_1_4); up_win = WIN_4;
      end
      WIN_4: begin
        has_up = 1'b1; up_bound = 27'(TH_4_16);  up_win = WIN_16;
        has_dn = 1'b1; lo_bound = 27'(TH_1_4);   dn_win = WIN_1;
      end
      WIN_16: begin
        has_up = 1'b1; up_bound = 27'(TH_16_64); up_win = WIN_64;
        has_dn = 1'b1; lo_bound = 27'(TH_4_16);  dn_win = WIN_4;
      end
      WIN_64: begin
        has_up = 1'b1; up_bound = 27'(TH_64_128); up_win = WIN_128;
        has_dn = 1'b1; lo_bound = 27'(TH_16_64);  dn_win = WIN_16;
      end
      default: begin
        has_dn = 1'b1; lo_bound = 27'(TH_64_128); dn_win = WIN_64;
      end
    endcase
    up_lim = up_bound + 27'(HYST);
    lo_lim = sat_sub(lo_bound, 27'(HYST));
    win_d  = area_q;
    if (has_up && ({1'b0, quot_sel} >= up_lim))      win_d = up_win;
    else if (has_dn && ({1'b0, quot_sel} < lo_lim))  win_d = dn_win;
  end

`ifdef SPEED_IIR_FILTER_EN
  logic signed [27:0] filt_q, filt_d, q_ext, filt_diff;
  assign q_ext     = $signed({2'b00, quot_sel});
  assign filt_diff = q_ext - filt_q;
  assign filt_d    = zero_q ? 28'sd0 : (filt_q + (filt_diff >>> FILT_SHIFT));

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n)                filt_q <= '0;
    else if (state_q == ST_FILT) filt_q <= filt_d;
  end
`endif

  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      zero_q    <= 1'b0;
      win_nxt_q <= WIN_1;
      area_q    <= WIN_1;
      speed_q   <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      valid_q <= (state_q == ST_DONE);
      if (state_q == ST_IDLE && bus.speed_cnt_valid_in)
        zero_q <= (bus.speed_pluse_time_cnt_in == '0);
      if (state_q == ST_MODE)
        win_nxt_q <= win_d;
      if (state_q == ST_DONE) begin
        area_q <= win_nxt_q;
`ifdef SPEED_IIR_FILTER_EN
        speed_q <= filt_q[SPEED_W-1:0];
`else
        speed_q <= quot_sel;
`endif
      end
      if (bus.speed_cnt_valid_in && state_q != ST_IDLE)
        overrun_q <= 1'b1;
    end
  end

  assign bus.speed_value_out            = speed_q;
  assign bus.speed_valid_out            = valid_q;
  assign bus.speed_area_count_value_out = area_q;
  assign bus.speed_area_count_valid_out = valid_q;
  assign bus.busy_out                   = busy;
  assign bus.overrun_out                = overrun_q;

endmodule

// File: tb/tb_speed_calc_divider_module.sv
// tb/tb_speed_calc_divider_module.sv - directed vector table plus overrun and reset sequences
module tb_speed_calc_divider_module;

  logic sys_clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sys_clk = ~sys_clk;

  speed_calc_divider_module_if bus ();

  speed_calc_divider_module dut (
    .sys_clk (sys_clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
    end
  endtask

  typedef struct {
    logic [25:0] dvd;
    logic [25:0] tim;
    logic [25:0] spd;
    logic [7:0]  win;
    int          lat;
  } vec_t;

  vec_t tbl[16];

  // Strobe once and wait for the result; cyc is the cycle (strobe = cycle 0) the valids appear.
  task automatic run_one(input logic [25:0] dvd, input logic [25:0] tim,
                         output int cyc, output logic [25:0] spd, output logic [7:0] win,
                         output logic coinc, output logic single);
    cyc = -1; spd = '0; win = '0; coinc = 1'b0; single = 1'b0;
    @(negedge sys_clk);
    bus.speed_pluse_count_dividend_in = dvd;
    bus.speed_pluse_time_cnt_in       = tim;
    bus.speed_cnt_valid_in            = 1'b1;
    @(posedge sys_clk); #1;
    bus.speed_cnt_valid_in = 1'b0;
    for (int k = 1; k <= 60; k++) begin
      @(posedge sys_clk); #1;
      if (bus.speed_valid_out) begin
        cyc   = k + 1;
        spd   = bus.speed_value_out;
        win   = bus.speed_area_count_value_out;
        coinc = bus.speed_area_count_valid_out;
        break;
      end
    end
    @(posedge sys_clk); #1;
    single = !bus.speed_valid_out && !bus.speed_area_count_valid_out;
  endtask

  initial begin
    int          cyc;
    logic [25:0] spd;
    logic [7:0]  win;
    logic        coinc, single;
    int          n_valid;
    string       nm;

    tbl[0]  = '{26'd390625,   26'd3125,     26'd125,      8'd4,  29};
    tbl[1]  = '{26'd1562500,  26'd12500,    26'd125,      8'd16, 29};
    tbl[2]  = '{26'd1562500,  26'd12500,    26'd125,      8'd16, 29};
    tbl[3]  = '{26'd1562500,  26'd0,        26'd0,        8'd4,  3};
    tbl[4]  = '{26'd50000000, 26'd1,        26'd50000000, 8'd16, 29};
    tbl[5]  = '{26'd50000000, 26'd67108863, 26'd0,        8'd4,  29};
    tbl[6]  = '{26'd67,       26'd1,        26'd67,       8'd4,  29};
    tbl[7]  = '{26'd68,       26'd1,        26'd68,       8'd16, 29};
    tbl[8]  = '{26'd60,       26'd1,        26'd60,       8'd16, 29};
    tbl[9]  = '{26'd59,       26'd1,        26'd59,       8'd4,  29};
    tbl[10] = '{26'd12,       26'd1,        26'd12,       8'd4,  29};
    tbl[11] = '{26'd11,       26'd1,        26'd11,       8'd1,  29};
    tbl[12] = '{26'd19,       26'd1,        26'd19,       8'd1,  29};
    tbl[13] = '{26'd20,       26'd1,        26'd20,       8'd4,  29};
    tbl[14] = '{26'd1000000,  26'd7,        26'd142857,   8'd16, 29};
    tbl[15] = '{26'd100,      26'd3,        26'd33,       8'd4,  29};

    bus.speed_pluse_count_dividend_in = '0;
    bus.speed_pluse_time_cnt_in       = '0;
    bus.speed_cnt_valid_in            = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("rst_speed",   32'(bus.speed_value_out), 0);
    check("rst_win",     32'(bus.speed_area_count_value_out), 1);
    check("rst_valid",   32'(bus.speed_valid_out), 0);
    check("rst_wvalid",  32'(bus.speed_area_count_valid_out), 0);
    check("rst_busy",    32'(bus.busy_out), 0);
    check("rst_overrun", 32'(bus.overrun_out), 0);
    @(negedge sys_clk);
    reset_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_one(tbl[i].dvd, tbl[i].tim, cyc, spd, win, coinc, single);
      nm = $sformatf("v%0d", i);
      check({nm, "_lat"},     32'(cyc), 32'(tbl[i].lat));
      check({nm, "_speed"},   32'(spd), 32'(tbl[i].spd));
      check({nm, "_win"},     32'(win), 32'(tbl[i].win));
      check({nm, "_coinc"},   32'(coinc), 1);
      check({nm, "_pulse"},   32'(single), 1);
      check({nm, "_idle"},    32'(bus.busy_out), 0);
      check({nm, "_overrun"}, 32'(bus.overrun_out), 0);
    end

    // Second strobe lands in cycle 10 of the first division and must be dropped.
    @(negedge sys_clk);
    bus.speed_pluse_count_dividend_in = 26'd390625;
    bus.speed_pluse_time_cnt_in       = 26'd3125;
    bus.speed_cnt_valid_in            = 1'b1;
    @(posedge sys_clk); #1;
    bus.speed_cnt_valid_in = 1'b0;
    n_valid = 0; cyc = -1;
    for (int k = 1; k <= 80; k++) begin
      if (k == 9) begin
        bus.speed_pluse_count_dividend_in = 26'd1000;
        bus.speed_pluse_time_cnt_in       = 26'd1;
        bus.speed_cnt_valid_in            = 1'b1;
      end
      if (k == 2) check("ovr_busy", 32'(bus.busy_out), 1);
      @(posedge sys_clk); #1;
      if (k == 9) bus.speed_cnt_valid_in = 1'b0;
      if (bus.speed_valid_out) begin
        n_valid++;
        if (n_valid == 1) begin
          cyc = k + 1;
          check("ovr_speed", 32'(bus.speed_value_out), 125);
          check("ovr_win",   32'(bus.speed_area_count_value_out), 16);
        end
      end
    end
    check("ovr_lat",     32'(cyc), 29);
    check("ovr_nvalid",  32'(n_valid), 1);
    check("ovr_sticky",  32'(bus.overrun_out), 1);
    repeat (5) @(posedge sys_clk);
    #1;
    check("ovr_sticky2", 32'(bus.overrun_out), 1);

    // Reset asserted in cycle 12 of a division.
    @(negedge sys_clk);
    bus.speed_pluse_count_dividend_in = 26'd50000000;
    bus.speed_pluse_time_cnt_in       = 26'd1;
    bus.speed_cnt_valid_in            = 1'b1;
    @(posedge sys_clk); #1;
    bus.speed_cnt_valid_in = 1'b0;
    repeat (11) @(posedge sys_clk);
    #2;
    reset_n = 1'b0;
    #1;
    check("mid_rst_speed",   32'(bus.speed_value_out), 0);
    check("mid_rst_win",     32'(bus.speed_area_count_value_out), 1);
    check("mid_rst_busy",    32'(bus.busy_out), 0);
    check("mid_rst_overrun", 32'(bus.overrun_out), 0);
    repeat (2) @(negedge sys_clk);
    reset_n = 1'b1;
    n_valid = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge sys_clk); #1;
      if (bus.speed_valid_out || bus.speed_area_count_valid_out) n_valid++;
    end
    check("mid_rst_nostrobe", 32'(n_valid), 0);
    check("mid_rst_idle",     32'(bus.busy_out), 0);

    run_one(26'd390625, 26'd3125, cyc, spd, win, coinc, single);
    check("post_rst_lat",   32'(cyc), 29);
    check("post_rst_speed", 32'(spd), 125);
    check("post_rst_win",   32'(win), 4);
    check("post_rst_ovr",   32'(bus.overrun_out), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
